serial_subtractor: RTL

- Bit-serial N-bit two's-complement subtractor computing diff = a - b, one bit per clock, LSB first, with a ripple borrow flop.
- Complements the team's combinational one-bit adder cells: the subtract direction, built as a small multi-cycle datapath unit for area-constrained lab designs.
- Start/ready/done handshake to a controlling FSM. Result, borrow and signed-overflow flags are held until the next operation completes.

---
 rtl/serial_arith_pkg.sv | 17 +
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor_full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 132 +++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
package serial_arith_pkg;

    localparam int SERIAL_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit counter width: one spare bit so cnt+1 on the last shift still fits.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int W = SERIAL_W_DEFAULT
) ();
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    modport master (
        output start, a, b,
        input  ready, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output ready, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor cell: x - y - bin = d - 2*bout.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b), LSB first, one bit per clock.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int W = SERIAL_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  sub_if
);
    localparam int CW = cnt_width(W);

    state_e          state_q, state_d;
    logic [W-1:0]    areg_q, areg_d;
    logic [W-1:0]    breg_q, breg_d;
    logic [W-1:0]    res_q, res_d;
    logic            bff_q, bff_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            amsb_q, amsb_d;
    logic            bmsb_q, bmsb_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic            ovf_q, ovf_d;

    logic            fs_d, fs_bout;
    logic            last_bit;

    assign last_bit = (cnt_q == CW'(W - 1));

    full_subtractor u_fs (
        .x    (areg_q[0]),
        .y    (breg_q[0]),
        .bin  (bff_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // State register; async reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: IDLE -> SHIFT on start, SHIFT -> DONE after W bits, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sub_if.start) state_d = SHIFT;
            SHIFT:   if (last_bit)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake decoded from state, results straight from their registers.
    always_comb begin
        sub_if.ready    = (state_q == IDLE);
        sub_if.done     = (state_q == DONE);
        sub_if.diff     = diff_q;
        sub_if.borrow   = borrow_q;
        sub_if.overflow = ovf_q;
    end

    // Datapath next-state: capture on start, shift one bit per SHIFT cycle,
    // publish results on the last shift so they are stable during DONE.
    always_comb begin
        areg_d   = areg_q;
        breg_d   = breg_q;
        res_d    = res_q;
        bff_d    = bff_q;
        cnt_d    = cnt_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (sub_if.start) begin
                    areg_d = sub_if.a;
                    breg_d = sub_if.b;
                    res_d  = '0;
                    bff_d  = 1'b0;
                    cnt_d  = '0;
                    amsb_d = sub_if.a[W-1];
                    bmsb_d = sub_if.b[W-1];
                end
            end
            SHIFT: begin
                areg_d = areg_q >> 1;
                breg_d = breg_q >> 1;
                res_d  = {fs_d, res_q[W-1:1]};
                bff_d  = fs_bout;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    diff_d   = {fs_d, res_q[W-1:1]};
                    borrow_d = fs_bout;
                    // Operand signs differ and result sign differs from minuend.
                    ovf_d    = (amsb_q != bmsb_q) && (fs_d != amsb_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg_q   <= '0;
            breg_q   <= '0;
            res_q    <= '0;
            bff_q    <= 1'b0;
            cnt_q    <= '0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            res_q    <= res_d;
            bff_q    <= bff_d;
            cnt_q    <= cnt_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule
